// File: rtl/ex_div_unit_if.sv
// Handshake/data bundle between the EX-stage operand muxes and the iterative divider.
// The master side drives requests; the slave side is the divider.
interface ex_div_unit_if #(
   parameter int XLEN = 32
);
   logic            START;
   logic [4:0]      SELECT;
   logic [XLEN-1:0] DATA1;
   logic [XLEN-1:0] DATA2;
   logic            FLUSH;
   logic [XLEN-1:0] RESULT;
   logic            BUSY;
   logic            DONE;
   logic            STALL;

   modport master (
      output START, SELECT, DATA1, DATA2, FLUSH,
      input  RESULT, BUSY, DONE, STALL
   );

   modport slave (
      input  START, SELECT, DATA1, DATA2, FLUSH,
      output RESULT, BUSY, DONE, STALL
   );
endinterface

// File: rtl/ex_div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// One quotient bit per cycle, then a single sign fix-up cycle before DONE.
module ex_div_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic         CLK,
   input  logic         RESET,
   ex_div_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN-1);

   state_t state_q, state_d;

   logic [XLEN-1:0]  rem_q, quo_q, dvs_q, result_q;
   logic [CNT_W-1:0] cnt_q;
   logic             op_rem_q, neg_q_q, neg_r_q, busy_q, done_q;

   logic                   sel_ok, op_signed, op_rem, div0, ovf, special, accept, stall;
   logic [XLEN-1:0]        special_res;
   logic signed [XLEN:0]   rem_sh, diff;

   function automatic logic [XLEN-1:0] mag(input logic sgn, input logic [XLEN-1:0] x);
      return (sgn && x[XLEN-1]) ? -x : x;
   endfunction

   function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] x);
      return neg ? -x : x;
   endfunction

   // Opcode decode: 011xx is the divide group; bit0 = unsigned, bit1 = remainder.
   always_comb begin
      sel_ok    = (bus.SELECT[4:2] == 3'b011);
      op_signed = ~bus.SELECT[0];
      op_rem    = bus.SELECT[1];
      div0      = (bus.DATA2 == '0);
      ovf       = op_signed && (bus.DATA1 == MIN_NEG) && (bus.DATA2 == ALL_ONES);
      special   = div0 || ovf;
      accept    = bus.START && (state_q == IDLE) && sel_ok && !bus.FLUSH;
      if (div0)
         special_res = op_rem ? bus.DATA1 : ALL_ONES;
      else
         special_res = op_rem ? '0 : MIN_NEG;
   end

   // The 33-bit shifted remainder keeps the trial-subtract borrow in its MSB.
   always_comb begin
      rem_sh = $signed({rem_q, quo_q[XLEN-1]});
      diff   = rem_sh - $signed({1'b0, dvs_q});
   end

   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept && !special) begin
               state_d = CALC;
               stall   = 1'b1;
            end
         end
         CALC: begin
            stall = 1'b1;
            if (bus.FLUSH)
               state_d = IDLE;
            else if (cnt_q == LAST_CNT)
               state_d = SIGN;
         end
         SIGN: begin
            stall   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         op_rem_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (special) begin
                     result_q <= special_res;
                     done_q   <= 1'b1;
                  end else begin
                     busy_q   <= 1'b1;
                     op_rem_q <= op_rem;
                     neg_q_q  <= op_signed && (bus.DATA1[XLEN-1] ^ bus.DATA2[XLEN-1]);
                     neg_r_q  <= op_signed && bus.DATA1[XLEN-1];
                     quo_q    <= mag(op_signed, bus.DATA1);
                     dvs_q    <= mag(op_signed, bus.DATA2);
                     rem_q    <= '0;
                     cnt_q    <= '0;
                  end
               end
            end
            CALC: begin
               if (bus.FLUSH) begin
                  busy_q <= 1'b0;
               end else begin
                  if (!diff[XLEN]) begin
                     rem_q <= diff[XLEN-1:0];
                     quo_q <= {quo_q[XLEN-2:0], 1'b1};
                  end else begin
                     rem_q <= rem_sh[XLEN-1:0];
                     quo_q <= {quo_q[XLEN-2:0], 1'b0};
                  end
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            SIGN: begin
               busy_q <= 1'b0;
               if (!bus.FLUSH) begin
                  result_q <= op_rem_q ? neg_if(neg_r_q, rem_q) : neg_if(neg_q_q, quo_q);
                  done_q   <= 1'b1;
               end
            end
            default: busy_q <= 1'b0;
         endcase
      end
   end

   assign bus.RESULT = result_q;
   assign bus.BUSY   = busy_q;
   assign bus.DONE   = done_q;
   assign bus.STALL  = stall;

endmodule

// File: tb/tb_ex_div_unit.sv
// Scoreboard bench for ex_div_unit: expected results queued at START, compared on DONE.
module tb_ex_div_unit;

   localparam logic [4:0] DIV  = 5'b01100;
   localparam logic [4:0] DIVU = 5'b01101;
   localparam logic [4:0] REM  = 5'b01110;
   localparam logic [4:0] REMU = 5'b01111;

   logic CLK = 1'b0;
   logic RESET = 1'b1;

   ex_div_unit_if bus ();

   ex_div_unit dut (
      .CLK  (CLK),
      .RESET(RESET),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] sb[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] model(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa, sbv;
      sa  = a;
      sbv = b;
      case (sel)
         DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return sa / sbv;
         end
         REM: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return sa % sbv;
         end
         DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Any DONE pops the scoreboard; a DONE with nothing queued is an error.
   always @(negedge CLK) begin
      if (bus.DONE === 1'b1) begin
         if (sb.size() == 0)
            check("unexpected_done", 32'd1, 32'd0);
         else
            check("result", bus.RESULT, sb.pop_front());
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic start_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                           output int s0);
      bus.START  = 1'b1;
      bus.SELECT = sel;
      bus.DATA1  = a;
      bus.DATA2  = b;
      #1 s0 = (bus.STALL === 1'b1) ? 1 : 0;
      @(posedge CLK);
      #1 bus.START = 1'b0;
   endtask

   task automatic wait_done(input int bound, output int cycles, output int stalls,
                            output bit busy_seen, output bit ok);
      cycles = 0; stalls = 0; busy_seen = 1'b0; ok = 1'b0;
      while (cycles < bound && !ok) begin
         @(negedge CLK);
         cycles++;
         if (bus.BUSY === 1'b1) busy_seen = 1'b1;
         if (bus.DONE === 1'b1) ok = 1'b1;
         else if (bus.STALL === 1'b1) stalls++;
      end
      if (!ok) check("timeout", 32'd0, 32'd1);
   endtask

   task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit special, input bit b2b);
      int s0, cycles, stalls;
      bit busy_seen, ok;
      if (!b2b) @(negedge CLK);
      sb.push_back(exp);
      start_op(sel, a, b, s0);
      wait_done(60, cycles, stalls, busy_seen, ok);
      if (ok) begin
         check("latency", cycles, special ? 32'd1 : 32'd34);
         check("stall_cycles", stalls + s0, special ? 32'd0 : 32'd34);
         check("busy_seen", {31'd0, busy_seen}, special ? 32'd0 : 32'd1);
         check("stall_in_done", {31'd0, bus.STALL}, 32'd0);
      end
   endtask

   initial begin
      int s0, cycles, stalls;
      bit busy_seen, ok;
      logic [31:0] a, b;
      logic [4:0]  sel;

      bus.START = 1'b0; bus.FLUSH = 1'b0; bus.SELECT = '0; bus.DATA1 = '0; bus.DATA2 = '0;
      repeat (3) @(negedge CLK);
      check("reset_result", bus.RESULT, 32'd0);
      check("reset_busy", {31'd0, bus.BUSY}, 32'd0);
      check("reset_done", {31'd0, bus.DONE}, 32'd0);
      check("reset_stall", {31'd0, bus.STALL}, 32'd0);
      RESET = 1'b0;

      run_op(DIV,  32'd20,        32'd3,         32'd6,         0, 0);
      run_op(REM,  32'd20,        32'd3,         32'd2,         0, 0);
      run_op(DIV,  -32'sd20,      32'd3,         32'hFFFF_FFFA, 0, 0);
      run_op(REM,  -32'sd20,      32'd3,         32'hFFFF_FFFE, 0, 0);
      run_op(REM,  32'd20,        -32'sd3,       32'd2,         0, 0);
      run_op(DIVU, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 0, 0);
      run_op(REMU, 32'hFFFF_FFFF, 32'd2,         32'd1,         0, 0);
      run_op(DIV,  32'hFFFF_FFFF, 32'd2,         32'd0,         0, 0);
      run_op(DIV,  32'd7,         32'd0,         32'hFFFF_FFFF, 1, 0);
      run_op(REMU, 32'd7,         32'd0,         32'd7,         1, 0);
      run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
      run_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 0);

      // Back-to-back: second START issued in the DONE cycle of the first.
      run_op(DIVU, 32'd10,  32'd3, 32'd3,  0, 0);
      run_op(DIVU, 32'd100, 32'd7, 32'd14, 0, 1);

      for (int i = 0; i < 8; i++) begin
         sel = DIV + 5'(i % 4);
         a   = $urandom;
         b   = (i % 2) ? 32'($urandom_range(1, 100)) : $urandom;
         if (i == 6) b = 32'd0;
         run_op(sel, a, b, model(sel, a, b),
                (b == 0) || (!sel[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF), 0);
      end

      // Invalid opcode is ignored.
      @(negedge CLK);
      start_op(5'b00000, 32'd20, 32'd3, s0);
      check("badsel_stall", s0, 32'd0);
      check("badsel_busy", {31'd0, bus.BUSY}, 32'd0);
      repeat (40) @(negedge CLK);

      // START while busy is ignored.
      @(negedge CLK);
      sb.push_back(32'd6);
      start_op(DIV, 32'd20, 32'd3, s0);
      repeat (10) @(negedge CLK);
      bus.START = 1'b1; bus.SELECT = DIVU; bus.DATA1 = 32'd100; bus.DATA2 = 32'd7;
      #1 check("busy_start_stall", {31'd0, bus.STALL}, 32'd1);
      @(posedge CLK);
      #1 bus.START = 1'b0;
      wait_done(60, cycles, stalls, busy_seen, ok);
      if (ok) check("latency_ignored", cycles + 10, 32'd34);
      repeat (40) @(negedge CLK);

      // FLUSH mid-operation: no DONE, RESULT keeps the last completed value.
      @(negedge CLK);
      start_op(DIVU, 32'd100, 32'd7, s0);
      repeat (15) @(negedge CLK);
      bus.FLUSH = 1'b1;
      @(posedge CLK);
      #1 bus.FLUSH = 1'b0;
      check("flush_busy", {31'd0, bus.BUSY}, 32'd0);
      check("flush_stall", {31'd0, bus.STALL}, 32'd0);
      check("flush_result", bus.RESULT, 32'd6);
      repeat (40) @(negedge CLK);
      check("flush_result_hold", bus.RESULT, 32'd6);

      // RESET mid-operation.
      start_op(DIV, 32'd20, 32'd3, s0);
      repeat (20) @(negedge CLK);
      RESET = 1'b1;
      @(posedge CLK);
      #1 RESET = 1'b0;
      check("rst_result", bus.RESULT, 32'd0);
      check("rst_busy", {31'd0, bus.BUSY}, 32'd0);
      check("rst_done", {31'd0, bus.DONE}, 32'd0);
      check("rst_stall", {31'd0, bus.STALL}, 32'd0);
      repeat (40) @(negedge CLK);

      // FLUSH together with START blocks even a special-case accept.
      bus.FLUSH = 1'b1;
      start_op(DIV, 32'd7, 32'd0, s0);
      bus.FLUSH = 1'b0;
      check("flush_start_done", {31'd0, bus.DONE}, 32'd0);
      check("flush_start_result", bus.RESULT, 32'd0);
      repeat (5) @(negedge CLK);

      check("sb_empty", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
